// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: fills instruction memory from a valid/ready loader
// stream, optionally zero-clearing it first, then releases the core.
//
// Optional feature macro: IMEM_CLEAR_EN
//   defined   -> CLEAR state present; reset and reload zero the whole
//                memory (one word per cycle) before loading starts.
//   undefined -> reset and reload go straight to LOAD; words past the
//                loaded image keep whatever they held.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-low
//   ld_valid    loader word valid
//   ld_ready    controller accepts a loader word (LOAD only)
//   ld_data     instruction word to store
//   ld_last     final word of the image, qualified by ld_valid
//   reload      in RUN: restart clear/load of the memory
//   mem_we      instruction memory write enable
//   mem_waddr   word index written
//   mem_wdata   data written
//   core_run    core may fetch; memory is stable
//   load_count  words loaded in the current image (0..DEPTH)
//   ovf         sticky: image filled DEPTH words without ld_last
module imem_load_ctrl #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    input  logic          reload,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          core_run,
    output logic [AW:0]   load_count,
    output logic          ovf
);

`ifdef IMEM_CLEAR_EN
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;
    localparam state_t INIT = CLEAR;
`else
    typedef enum logic [1:0] {
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;
    localparam state_t INIT = LOAD;
`endif

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] index_q;
    logic [AW-1:0] index_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          run_q;
    logic          run_d;
    logic          we_q;
    logic          we_d;
    logic [AW-1:0] waddr_q;
    logic [AW-1:0] waddr_d;
    logic [31:0]   wdata_q;
    logic [31:0]   wdata_d;
    logic          clearing;
    logic          hs;
    logic          at_last;

`ifdef IMEM_CLEAR_EN
    assign clearing = (state_q == CLEAR);
`else
    assign clearing = 1'b0;
`endif

    // Gating with reset keeps the loader stalled and the memory
    // untouched during any cycle in which reset is held low.
    assign ld_ready = reset && (state_q == LOAD);
    assign hs       = ld_valid && ld_ready;
    assign at_last  = (index_q == LAST);

    // Clear writes come straight from the index counter so the
    // first zero write lands in the first cycle reset is released.
    assign mem_we     = reset && (we_q || clearing);
    assign mem_waddr  = clearing ? index_q : waddr_q;
    assign mem_wdata  = clearing ? 32'd0 : wdata_q;
    assign core_run   = run_q;
    assign load_count = count_q;
    assign ovf        = ovf_q;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
`ifdef IMEM_CLEAR_EN
            CLEAR: begin
                index_d = index_q + 1'b1;
                if (at_last) begin
                    state_d = LOAD;
                    index_d = '0;
                end
            end
`endif
            LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = index_q;
                    wdata_d = ld_data;
                    index_d = index_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (ld_last || at_last) begin
                        state_d = RUN;
                    end
                    if (at_last && !ld_last) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = INIT;
                    index_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
        // Asserts one cycle after entering RUN (after the final
        // write) and drops in the same edge that leaves RUN.
        run_d = (state_q == RUN) && (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            index_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            run_q   <= run_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: directed bench with a write scoreboard for
// imem_load_ctrl; works with and without IMEM_CLEAR_EN.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic        reload = 1'b0;
    logic [31:0] ld_data = 32'd0;
    logic        ld_ready;
    logic        mem_we;
    logic [5:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_run;
    logic [6:0]  load_count;
    logic        ovf;

`ifdef IMEM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  idx = 0;
    int  cnt = 0;

    imem_load_ctrl #(.DEPTH(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .core_run   (core_run),
        .load_count (load_count),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input int a,
                        input logic [31:0] d);
        wr_t e;
        e.cyc  = c;
        e.addr = 6'(a);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Clear phase starts in the current cycle (if enabled).
    task automatic do_clear();
        idx = 0;
        cnt = 0;
        if (CLR) begin
            for (int i = 0; i < 64; i++) begin
                push(cyc + i, i, 32'd0);
            end
            repeat (64) step();
        end
    endtask

    // Drive one word; handshake at the coming edge.
    task automatic send(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        push(cyc + 1, idx, d);
        idx = (idx + 1) % 64;
        cnt++;
        step();
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            if (sb.size() == 0) begin
                check("spurious_we", 32'(mem_we), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(mem_waddr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check("missing_we", 32'(mem_we), 32'd1);
        end
    end

    initial begin
        // Reset with a loader word pending.
        ld_valid = 1'b1;
        repeat (3) step();
        at_neg();
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_run", 32'(core_run), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);

        step();
        ld_valid = 1'b0;
        reset = 1'b1;
        at_neg();
        check("rel_ready", 32'(ld_ready), CLR ? 32'd0 : 32'd1);
        do_clear();
        at_neg();
        check("load_ready", 32'(ld_ready), 32'd1);

        // reload ignored in LOAD
        reload = 1'b1;
        step();
        reload = 1'b0;
        at_neg();
        check("rl_load_ready", 32'(ld_ready), 32'd1);
        check("rl_load_count", 32'(load_count), 32'd0);

        // Three-word image, valid held throughout
        send(32'h00A50533, 1'b0);
        send(32'h00052483, 1'b0);
        send(32'h01849663, 1'b1);
        at_neg();
        check("img3_count", 32'(load_count), 32'd3);
        check("img3_ready", 32'(ld_ready), 32'd0);
        check("img3_run_early", 32'(core_run), 32'd0);
        step();
        at_neg();
        check("img3_run", 32'(core_run), 32'd1);
        check("img3_ovf", 32'(ovf), 32'd0);
        step();
        ld_valid = 1'b0;
        ld_last = 1'b0;

        // reload from RUN
        reload = 1'b1;
        step();
        reload = 1'b0;
        at_neg();
        check("rl_run", 32'(core_run), 32'd0);
        check("rl_count", 32'(load_count), 32'd0);
        check("rl_ovf", 32'(ovf), 32'd0);
        do_clear();

        // ld_valid toggled 1,0,1,0
        send(32'hCAFE0000, 1'b0);
        ld_valid = 1'b0;
        step();
        send(32'hCAFE0001, 1'b0);
        ld_valid = 1'b0;
        step();
        at_neg();
        check("tog_count", 32'(load_count), 32'd2);

        // Fill to DEPTH without ld_last
        for (int i = 2; i < 64; i++) begin
            send(32'h1000_0000 + 32'(i * 7), 1'b0);
        end
        at_neg();
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_ready", 32'(ld_ready), 32'd0);
        check("ovf_count", 32'(load_count), 32'd64);
        step();
        at_neg();
        check("ovf_run", 32'(core_run), 32'd1);
        step();
        ld_valid = 1'b0;

        reload = 1'b1;
        step();
        reload = 1'b0;
        at_neg();
        check("rl2_ovf", 32'(ovf), 32'd0);
        check("rl2_count", 32'(load_count), 32'd0);
        do_clear();

        // Reset after 10 words, valid held
        for (int i = 0; i < 10; i++) begin
            send(32'hABCD_0000 + 32'(i), 1'b0);
        end
        reset = 1'b0;
        void'(sb.pop_back());
        at_neg();
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_ready", 32'(ld_ready), 32'd0);
        step();
        at_neg();
        check("mid_rst_count", 32'(load_count), 32'd0);
        check("mid_rst_we2", 32'(mem_we), 32'd0);
        check("mid_rst_run", 32'(core_run), 32'd0);
        step();
        ld_valid = 1'b0;
        reset = 1'b1;
        at_neg();
        check("rel2_ready", 32'(ld_ready), CLR ? 32'd0 : 32'd1);
        do_clear();

        // One-word image
        send(32'h0000_0013, 1'b1);
        ld_valid = 1'b0;
        ld_last = 1'b0;
        at_neg();
        check("img1_count", 32'(load_count), 32'(cnt));
        step();
        at_neg();
        check("img1_run", 32'(core_run), 32'd1);

        repeat (3) step();
        at_neg();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
